// File: rtl/serial_tx_m.sv
// serial_tx_m: parallel-to-serial transmitter, MSB first, with a ready/load handshake.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_tx_m #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [W-1:0] d,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         sout_vld,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SERIAL_TX_PARITY_EN
    , PARITY
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sout_q, sout_d;
  logic           soutVld_q, soutVld_d;
  logic           done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic lastBit;
  logic frameEnd;

  assign lastBit = (state_q == SHIFT) && (cnt_q == LAST);

  // The final cycle of a frame is where a new word may be accepted gaplessly.
`ifdef SERIAL_TX_PARITY_EN
  assign frameEnd = (state_q == PARITY);
`else
  assign frameEnd = lastBit;
`endif

  assign ready    = (state_q == IDLE) || frameEnd;
  assign sout     = sout_q;
  assign sout_vld = soutVld_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (ready && load) begin
      state_d = SHIFT;
      shift_d = d;
      cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = ^d;
`endif
    end else if (frameEnd) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + CW'(1);
`ifdef SERIAL_TX_PARITY_EN
      if (lastBit) state_d = PARITY;
`endif
    end

    // Outputs are precomputed from the next state so they come straight from flops.
    sout_d    = 1'b0;
    soutVld_d = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      SHIFT: begin
        sout_d    = shift_d[W-1];
        soutVld_d = 1'b1;
`ifndef SERIAL_TX_PARITY_EN
        done_d    = (cnt_d == LAST);
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        sout_d    = par_d;
        soutVld_d = 1'b1;
        done_d    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      sout_q    <= 1'b0;
      soutVld_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      sout_q    <= sout_d;
      soutVld_q <= soutVld_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_m.sv
// Scoreboard bench for serial_tx_m: a W=8 and a W=1 instance share clock and reset.
module tb_serial_tx_m;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL8 = 8 + PB;
  localparam int FL1 = 1 + PB;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] d8;
  logic       load8, ready8, sout8, vld8, done8;
  logic [0:0] d1;
  logic       load1, ready1, sout1, vld1, done1;

  logic [1:0] exp8[$];
  logic [1:0] exp1[$];
  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_tx_m #(.W(8)) u8 (
    .clk(clk), .rst_(rst_), .d(d8), .load(load8),
    .ready(ready8), .sout(sout8), .sout_vld(vld8), .done(done8)
  );

  serial_tx_m #(.W(1)) u1 (
    .clk(clk), .rst_(rst_), .d(d1), .load(load1),
    .ready(ready1), .sout(sout1), .sout_vld(vld1), .done(done1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Queue one W=8 frame: bits MSB first, then the hand-computed parity bit if built in.
  task automatic pushFrame8(input logic [7:0] w, input logic par);
    for (int k = 0; k < 8; k++)
      exp8.push_back({w[7-k], (PB == 0 && k == 7) ? 1'b1 : 1'b0});
    if (PB == 1) exp8.push_back({par, 1'b1});
  endtask

  task automatic pushFrame1(input logic b, input logic par);
    exp1.push_back({b, (PB == 0) ? 1'b1 : 1'b0});
    if (PB == 1) exp1.push_back({par, 1'b1});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word for one accepting edge, then scramble d to prove it is not resampled.
  task automatic applyStimulus(input logic [7:0] w, input logic par);
    d8 = w;
    load8 = 1'b1;
    pushFrame8(w, par);
    tick(1);
    load8 = 1'b0;
    d8 = ~w;
  endtask

  always @(negedge clk) begin
    logic [1:0] expBits;
    if (vld8) begin
      if (exp8.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL u8 unexpected bit: got sout=%0b done=%0b, required no valid bit", sout8, done8);
      end else begin
        expBits = exp8.pop_front();
        checkOutput("u8 sout/done", 32'({sout8, done8}), 32'(expBits));
      end
    end else begin
      checkOutput("u8 idle sout/done", 32'({sout8, done8}), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] expBits;
    if (vld1) begin
      if (exp1.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL u1 unexpected bit: got sout=%0b done=%0b, required no valid bit", sout1, done1);
      end else begin
        expBits = exp1.pop_front();
        checkOutput("u1 sout/done", 32'({sout1, done1}), 32'(expBits));
      end
    end else begin
      checkOutput("u1 idle sout/done", 32'({sout1, done1}), 32'd0);
    end
  end

  initial begin
    int doneCount;
    rst_ = 1'b1;
    load8 = 1'b0;
    d8 = 8'h00;
    load1 = 1'b0;
    d1 = 1'b0;
    #1 rst_ = 1'b0;
    #2;
    checkOutput("reset ready", 32'(ready8), 32'd1);
    checkOutput("reset sout", 32'(sout8), 32'd0);
    checkOutput("reset sout_vld", 32'(vld8), 32'd0);
    checkOutput("reset done", 32'(done8), 32'd0);
    @(posedge clk);
    #2 rst_ = 1'b1;
    tick(2);

    // Single A5 frame with ready tracked through every bit cycle.
    applyStimulus(8'hA5, 1'b0);
    for (int c = 0; c < FL8; c++) begin
      @(negedge clk);
      checkOutput("ready in frame", 32'(ready8), 32'(c == FL8 - 1));
    end
    tick(3);
    checkOutput("ready after frame", 32'(ready8), 32'd1);

    // Parity vectors: 07 has three ones, 03 has two.
    applyStimulus(8'h07, 1'b1);
    tick(FL8 + 1);
    applyStimulus(8'h03, 1'b0);
    tick(FL8 + 1);

    // Load pulsed mid-frame must be ignored entirely.
    applyStimulus(8'hA5, 1'b0);
    tick(2);
    d8 = 8'h55;
    load8 = 1'b1;
    tick(1);
    load8 = 1'b0;
    tick(FL8 - 4 + 3);
    checkOutput("ignored load idle ready", 32'(ready8), 32'd1);
    checkOutput("ignored load idle vld", 32'(vld8), 32'd0);

    // Back-to-back FF then 00 with load held high.
    d8 = 8'hFF;
    load8 = 1'b1;
    pushFrame8(8'hFF, 1'b0);
    pushFrame8(8'h00, 1'b0);
    tick(1);
    doneCount = 0;
    for (int c = 0; c < 2 * FL8; c++) begin
      @(negedge clk);
      checkOutput("b2b sout_vld", 32'(vld8), 32'd1);
      if (done8) doneCount++;
      if (c == FL8 - 1) d8 = 8'h00;
      if (c == FL8) load8 = 1'b0;
    end
    checkOutput("b2b done pulses", 32'(doneCount), 32'd2);
    tick(3);

    // Reset after three bits aborts the rest of the frame.
    applyStimulus(8'hA5, 1'b0);
    tick(2);
    #1 rst_ = 1'b0;
    #1;
    checkOutput("midframe reset ready", 32'(ready8), 32'd1);
    checkOutput("midframe reset sout", 32'(sout8), 32'd0);
    checkOutput("midframe reset vld", 32'(vld8), 32'd0);
    checkOutput("midframe reset done", 32'(done8), 32'd0);
    exp8.delete();
    @(posedge clk);
    #2 rst_ = 1'b1;
    tick(FL8 + 4);
    checkOutput("no bits after reset", 32'(exp8.size()), 32'd0);
    applyStimulus(8'h03, 1'b0);
    tick(FL8 + 1);

    // W=1 back-to-back: 1 then 0.
    d1 = 1'b1;
    load1 = 1'b1;
    pushFrame1(1'b1, 1'b1);
    pushFrame1(1'b0, 1'b0);
    tick(1);
    for (int c = 0; c < 2 * FL1; c++) begin
      @(negedge clk);
      checkOutput("w1 sout_vld", 32'(vld1), 32'd1);
      checkOutput("w1 ready", 32'(ready1), 32'((c % FL1) == FL1 - 1));
      checkOutput("w1 done", 32'(done1), 32'((c % FL1) == FL1 - 1));
      if (c == FL1 - 1) d1 = 1'b0;
      if (c == FL1) load1 = 1'b0;
    end
    tick(4);

    checkOutput("u8 scoreboard drained", 32'(exp8.size()), 32'd0);
    checkOutput("u1 scoreboard drained", 32'(exp1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_tx_m.md
# serial_tx_m

Parallel-to-serial transmitter: accepts a W-bit word from a parallel register stage through a ready/load handshake and shifts it out MSB first, one bit per clock, with a bit-valid strobe and an end-of-word pulse. It is the sending end of the serial link whose receiving end reassembles bits into a register word. An optional even-parity bit is appended after the data bits.

## Interface
- W, default 8: data word width; legal range W >= 1.
- clk  input  1  clock; all state changes on rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- d  input  W  parallel data word; sampled only on an accepted load.
- load  input  1  request to transmit d; accepted on a rising edge where load && ready.
- ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_vld  output  1  sout carries a valid bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a frame.

## Operation
- Reset (rst_ low, immediate, no clock needed): state IDLE, ready=1, sout=0, sout_vld=0, done=0, shift register and bit counter cleared. Reset mid-frame aborts the frame; no remaining bits are sent.
- States: IDLE, SHIFT, PARITY (PARITY exists only with SERIAL_TX_PARITY_EN).
- IDLE: ready=1, sout_vld=0, sout=0. On load: capture d into shift register, counter=0, go SHIFT.
- SHIFT: sout = shift register MSB, sout_vld=1. Each edge shifts left by one (zero fill) and increments counter. Counter width $clog2(W+1); no wrap within a frame.
- Last data bit (counter == W-1): without parity, done=1 and ready=1 this cycle; with parity, go PARITY on next edge.
- PARITY: sout = XOR of all W captured bits (even parity: total ones incl. parity bit is even), sout_vld=1, done=1, ready=1.
- Frame end (ready=1 in last bit cycle): if load is high at that edge, capture new d and start a new SHIFT with counter=0 (gapless back-to-back); else return IDLE.
- load while ready=0: ignored; d not sampled; no error flag.
- d changes after acceptance have no effect on the frame in flight.
- W=1: SHIFT lasts exactly one cycle; counter==W-1 holds on entry.

## Timing
- Latency: load accepted at edge N -> first bit (d[W-1]) on sout with sout_vld=1 in cycle after edge N.
- Frame length: W cycles without parity, W+1 with parity; bit k (MSB=k=0) visible in cycle k after acceptance.
- done: exactly one cycle per frame, in the final bit cycle; never asserted in IDLE.
- ready: combinational from state/counter only (never from load); 1 in IDLE and final bit cycle, 0 otherwise.
- Back-to-back throughput: one word per W (or W+1) cycles, zero idle cycles.
- All outputs registered-state-derived; no combinational path from d or load to sout, sout_vld, done.

## Configuration
- SERIAL_TX_PARITY_EN defined: PARITY state compiled in; each frame is W data bits plus one even-parity bit; done/ready move to the parity cycle.
- SERIAL_TX_PARITY_EN undefined: no PARITY state or parity logic; frame is W data bits; done/ready in last data bit cycle.

## Test plan
- Reset: hold rst_ low mid-frame (W=8, d=8'hA5, after 3 bits) -> outputs immediately ready=1, sout=0, sout_vld=0, done=0; no further bits after release until new load.
- Single frame W=8, d=8'hA5, no parity -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sout_vld=1; done=1 only on 8th; ready=0 cycles 1-7.
- Parity build, d=8'h07 -> 8 data bits 0,0,0,0,0,1,1,1 then parity bit 1; done on 9th cycle; d=8'h03 -> parity bit 0.
- Back-to-back: load held high with d=8'hFF then 8'h00 presented at final-bit edge -> 16 contiguous valid bits (eight 1s, eight 0s), sout_vld never drops, two done pulses.
- Ignored load: pulse load with d=8'h55 during cycle 4 of an 8'hA5 frame -> 8'hA5 bits unaffected, no extra frame follows.
- W=1: d=1 then d=0 back-to-back -> sout 1 then 0, sout_vld=1, done=1 and ready=1 on both cycles (no parity build).
